// File: rtl/sram_like_responder_if.sv
// SRAM-like request/response bus: address phase (req..wdata -> addr_ok), data phase (data_ok/rdata).
interface sram_like_responder_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned OUT_W = $clog2(DEPTH) + 1;

  logic             req;
  logic             wr;
  logic [1:0]       size;
  logic [3:0]       wstrb;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic             addr_ok;
  logic             data_ok;
  logic [31:0]      rdata;
  logic [OUT_W-1:0] outstanding;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata, outstanding
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata, outstanding
  );
endinterface

// File: rtl/sram_like_responder.sv
// Responder for the SRAM-like bus: word memory, writes commit at acceptance,
// in-order responses no earlier than RESP_DELAY cycles after acceptance.
module sram_like_responder #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RESP_DELAY = 1
) (
  input logic                  clk,
  input logic                  resetn,
  sram_like_responder_if.slave bus
);
  localparam int unsigned OUT_W = $clog2(DEPTH) + 1;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WORDS = 1 << ADDR_W;
  localparam logic [7:0]       DELAY = 8'(RESP_DELAY);
  localparam logic [OUT_W-1:0] FULL  = OUT_W'(DEPTH);

  logic [31:0]      mem    [WORDS];
  logic [31:0]      q_data [DEPTH];
  logic [7:0]       q_ts   [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [OUT_W-1:0] count;
  logic [7:0]       cnt;
  logic             data_ok_q;
  logic [31:0]      rdata_q;

  logic             accept, retire;
  logic [ADDR_W-1:0] idx;
  logic [31:0]      push_data;
  logic [PTR_W-1:0] head_n, tail_n;
  logic [OUT_W-1:0] count_n;
  logic [7:0]       cnt_n, next_ts;
  logic [31:0]      next_data;
  logic             next_valid, data_ok_n;
  logic             unused_bits;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A response presented this cycle always retires at the closing edge.
  assign retire      = data_ok_q;
  assign accept      = resetn && bus.req && ((count < FULL) || retire);
  assign idx         = bus.addr[ADDR_W+1:2];
  assign push_data   = bus.wr ? 32'h0 : mem[idx];
  assign unused_bits = ^{bus.size, bus.addr[1:0], bus.addr[31:ADDR_W+2]};

  assign bus.addr_ok     = accept;
  assign bus.data_ok     = data_ok_q;
  assign bus.rdata       = rdata_q;
  assign bus.outstanding = count;

  // Next pointer/count state and which entry will be at the head after this edge.
  always_comb begin
    head_n     = retire ? ptr_inc(head) : head;
    tail_n     = accept ? ptr_inc(tail) : tail;
    count_n    = count + OUT_W'(accept) - OUT_W'(retire);
    cnt_n      = cnt + 8'd1;
    next_valid = 1'b1;
    next_ts    = q_ts[head_n];
    next_data  = q_data[head_n];
    // Nothing left behind the retiring entry: the head is the one being pushed now.
    if (count - OUT_W'(retire) == '0) begin
      next_valid = accept;
      next_ts    = cnt;
      next_data  = push_data;
    end
    data_ok_n = next_valid && ((cnt_n - next_ts) >= DELAY);
  end

  // Control state, cycle counter and registered response outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      cnt       <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      head      <= head_n;
      tail      <= tail_n;
      count     <= count_n;
      cnt       <= cnt_n;
      data_ok_q <= data_ok_n;
      rdata_q   <= data_ok_n ? next_data : 32'h0;
    end
  end

  // Queue payload storage; validity is tracked by head/tail/count.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_data[tail] <= push_data;
      q_ts[tail]   <= cnt;
    end
  end

  // Byte-strobed memory write at acceptance; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && bus.wr) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wstrb[i]) mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: two instances (RESP_DELAY 1 and 10) checked every
// cycle against a queue/cycle-index model, plus directed literal expectations.
module tb_sram_like_responder;
  localparam int unsigned DEPTH = 4;
  localparam int RD_A = 1;
  localparam int RD_B = 10;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sram_like_responder_if #(.DEPTH(DEPTH)) bus_a ();
  sram_like_responder_if #(.DEPTH(DEPTH)) bus_b ();

  sram_like_responder #(.ADDR_W(10), .DEPTH(DEPTH), .RESP_DELAY(RD_A)) dut_a (
    .clk(clk), .resetn(resetn), .bus(bus_a.slave));
  sram_like_responder #(.ADDR_W(10), .DEPTH(DEPTH), .RESP_DELAY(RD_B)) dut_b (
    .clk(clk), .resetn(resetn), .bus(bus_b.slave));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] data;
    int          acc;
  } rsp_t;

  rsp_t        mq [2][$];
  logic [31:0] mm [2][1024];
  logic [31:0] coll [2][$];
  int          coll_cyc [2][$];
  int          maxo [2];
  int          stall [2];
  int          cyc = 0;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  // Per-cycle compare against the model, then advance the model past the coming edge.
  always @(negedge clk) begin : cmp_proc
    logic        s_req [2], s_wr [2], s_aok [2], s_dok [2];
    logic [3:0]  s_strb [2];
    logic [31:0] s_addr [2], s_wdata [2], s_rdata [2];
    logic [31:0] s_out [2];
    logic        exp_ok, exp_dok;
    logic [31:0] exp_rd;
    int          exp_out, rd, w;
    s_req[0] = bus_a.req; s_wr[0] = bus_a.wr; s_strb[0] = bus_a.wstrb;
    s_addr[0] = bus_a.addr; s_wdata[0] = bus_a.wdata; s_aok[0] = bus_a.addr_ok;
    s_dok[0] = bus_a.data_ok; s_rdata[0] = bus_a.rdata; s_out[0] = 32'(bus_a.outstanding);
    s_req[1] = bus_b.req; s_wr[1] = bus_b.wr; s_strb[1] = bus_b.wstrb;
    s_addr[1] = bus_b.addr; s_wdata[1] = bus_b.wdata; s_aok[1] = bus_b.addr_ok;
    s_dok[1] = bus_b.data_ok; s_rdata[1] = bus_b.rdata; s_out[1] = 32'(bus_b.outstanding);
    for (int i = 0; i < 2; i++) begin
      rd = (i == 0) ? RD_A : RD_B;
      exp_ok = 1'b0; exp_dok = 1'b0; exp_rd = 32'h0; exp_out = 0;
      if (!resetn) begin
        mq[i].delete();
      end else begin
        if (mq[i].size() > 0) begin
          if (cyc - mq[i][0].acc >= rd) begin
            exp_dok = 1'b1;
            exp_rd  = mq[i][0].data;
          end
        end
        exp_out = mq[i].size();
        exp_ok  = s_req[i] && (mq[i].size() < int'(DEPTH) || exp_dok);
      end
      check($sformatf("dut%0d addr_ok cyc %0d", i, cyc), 32'(s_aok[i]), 32'(exp_ok));
      check($sformatf("dut%0d data_ok cyc %0d", i, cyc), 32'(s_dok[i]), 32'(exp_dok));
      check($sformatf("dut%0d rdata cyc %0d", i, cyc), s_rdata[i], exp_rd);
      check($sformatf("dut%0d outstanding cyc %0d", i, cyc), s_out[i], 32'(exp_out));
      if (s_dok[i]) begin
        coll[i].push_back(s_rdata[i]);
        coll_cyc[i].push_back(cyc);
      end
      if (int'(s_out[i]) > maxo[i]) maxo[i] = int'(s_out[i]);
      if (s_req[i] && !s_aok[i]) stall[i]++;
      if (resetn) begin
        if (exp_dok) void'(mq[i].pop_front());
        if (exp_ok) begin
          w = int'(s_addr[i][11:2]);
          if (s_wr[i]) begin
            for (int b = 0; b < 4; b++)
              if (s_strb[i][b]) mm[i][w][8*b +: 8] = s_wdata[i][8*b +: 8];
            mq[i].push_back('{data: 32'h0, acc: cyc});
          end else begin
            mq[i].push_back('{data: mm[i][w], acc: cyc});
          end
        end
      end
    end
    cyc++;
  end

  task automatic drive(input int i, input logic r, input logic w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    if (i == 0) begin
      bus_a.req = r; bus_a.wr = w; bus_a.size = 2'd2; bus_a.wstrb = s; bus_a.addr = a; bus_a.wdata = d;
    end else begin
      bus_b.req = r; bus_b.wr = w; bus_b.size = 2'd2; bus_b.wstrb = s; bus_b.addr = a; bus_b.wdata = d;
    end
  endtask

  // Present one request and hold it until accepted; returns just after the accepting edge.
  task automatic issue(input int i, input logic w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    logic acc;
    int   n;
    n = 0;
    drive(i, 1'b1, w, s, a, d);
    forever begin
      @(negedge clk);
      acc = (i == 0) ? bus_a.addr_ok : bus_b.addr_ok;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept timeout dut%0d addr %h: no addr_ok after %0d cycles", i, a, n);
        break;
      end
    end
  endtask

  task automatic idle(input int i);
    drive(i, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pat(input int k);
    return 32'hC0DE_0000 | 32'(k);
  endfunction

  initial begin
    int bad;
    idle(0);
    idle(1);
    maxo[0] = 0; maxo[1] = 0; stall[0] = 0; stall[1] = 0;

    // Reset state, including addr_ok gated by reset while req is high.
    wait_cycles(3);
    drive(0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check("reset addr_ok", 32'(bus_a.addr_ok), 32'h0);
    check("reset data_ok", 32'(bus_a.data_ok), 32'h0);
    check("reset rdata", bus_a.rdata, 32'h0);
    check("reset outstanding", 32'(bus_b.outstanding), 32'h0);
    idle(0);
    wait_cycles(1);
    resetn = 1'b1;
    wait_cycles(2);

    // Word write then read of the same word on the next cycle.
    coll[0].delete();
    issue(0, 1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF);
    issue(0, 1'b0, 4'h0, 32'h100, 32'h0);
    idle(0);
    wait_cycles(4);
    check("wr/rd count", 32'(coll[0].size()), 32'd2);
    if (coll[0].size() == 2) begin
      check("write rsp rdata", coll[0][0], 32'h0);
      check("read rsp rdata", coll[0][1], 32'hDEAD_BEEF);
      check("wr/rd spacing", 32'(coll_cyc[0][1] - coll_cyc[0][0]), 32'd1);
    end

    // Byte strobes, read through an aliasing byte address.
    coll[0].delete();
    issue(0, 1'b1, 4'hF, 32'h40, 32'h1122_3344);
    issue(0, 1'b1, 4'b0101, 32'h40, 32'hAABB_CCDD);
    issue(0, 1'b0, 4'h0, 32'h42, 32'h0);
    idle(0);
    wait_cycles(4);
    check("strobe count", 32'(coll[0].size()), 32'd3);
    if (coll[0].size() == 3) check("strobe merge", coll[0][2], 32'h11BB_33DD);

    // Preload slow instance.
    for (int k = 0; k < 20; k++) issue(1, 1'b1, 4'hF, 32'(4 * k), 32'h1000 + 32'(k));
    idle(1);
    wait_cycles(20);

    // Back-pressure: six reads against a 4-deep queue with delay 10.
    coll[1].delete(); maxo[1] = 0; stall[1] = 0;
    for (int k = 0; k < 6; k++) issue(1, 1'b0, 4'h0, 32'(4 * k), 32'h0);
    idle(1);
    wait_cycles(20);
    check("bp stall cycles", 32'(stall[1]), 32'd6);
    check("bp peak outstanding", 32'(maxo[1]), 32'd4);
    check("bp rsp count", 32'(coll[1].size()), 32'd6);
    bad = 0;
    for (int k = 0; k < coll[1].size(); k++) if (coll[1][k] !== 32'h1000 + 32'(k)) bad++;
    check("bp rsp order", 32'(bad), 32'd0);

    // Streaming 300 reads across counter wrap.
    for (int k = 0; k < 300; k++) issue(0, 1'b1, 4'hF, 32'(4 * k), pat(k));
    idle(0);
    wait_cycles(3);
    coll[0].delete(); coll_cyc[0].delete();
    for (int k = 0; k < 300; k++) issue(0, 1'b0, 4'h0, 32'(4 * k), 32'h0);
    idle(0);
    wait_cycles(3);
    check("stream count", 32'(coll[0].size()), 32'd300);
    if (coll[0].size() == 300) begin
      bad = 0;
      for (int k = 0; k < 300; k++) if (coll[0][k] !== pat(k)) bad++;
      check("stream data", 32'(bad), 32'd0);
      check("stream no gap", 32'(coll_cyc[0][299] - coll_cyc[0][0]), 32'd299);
    end

    // Asynchronous reset with three reads in flight.
    coll[1].delete();
    for (int k = 0; k < 3; k++) issue(1, 1'b0, 4'h0, 32'(4 * k), 32'h0);
    idle(1);
    wait_cycles(2);
    check("pre-reset outstanding", 32'(bus_b.outstanding), 32'd3);
    #2;
    resetn = 1'b0;
    #1;
    check("async reset data_ok", 32'(bus_b.data_ok), 32'h0);
    check("async reset outstanding", 32'(bus_b.outstanding), 32'h0);
    wait_cycles(2);
    #2;
    resetn = 1'b1;
    wait_cycles(15);
    check("no stale rsp", 32'(coll[1].size()), 32'd0);
    issue(1, 1'b0, 4'h0, 32'h4, 32'h0);
    idle(1);
    wait_cycles(14);
    check("post-reset rsp count", 32'(coll[1].size()), 32'd1);
    if (coll[1].size() == 1) check("post-reset data", coll[1][0], 32'h1001);

    // Accept and retire together on a full queue.
    coll[1].delete(); maxo[1] = 0;
    for (int k = 0; k < 20; k++) issue(1, 1'b0, 4'h0, 32'(4 * k), 32'h0);
    idle(1);
    wait_cycles(20);
    check("full rsp count", 32'(coll[1].size()), 32'd20);
    bad = 0;
    for (int k = 0; k < coll[1].size(); k++) if (coll[1][k] !== 32'h1000 + 32'(k)) bad++;
    check("full rsp order", 32'(bad), 32'd0);
    check("full peak outstanding", 32'(maxo[1]), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
